// File: rtl/bus_message_router.sv
// Message crossbar: per-destination FIFOs fed through round-robin arbiters, one push and one pop per destination per cycle.
// Optional macro BUS_ROUTER_DROP_COUNT_EN adds drop_count_o, a saturating count of discarded messages.
module bus_message_router #(
  parameter int NUM_NODES  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_NODES-1:0]       snd_val_i,
  output logic [NUM_NODES-1:0]       snd_ack_o,
  input  logic [NUM_NODES-1:0][31:0] snd_dst_i,
  input  logic [NUM_NODES-1:0][31:0] snd_tag_i,
  input  logic [NUM_NODES-1:0][63:0] snd_msg_i,
  output logic [NUM_NODES-1:0]       rcv_val_o,
  input  logic [NUM_NODES-1:0]       rcv_rdy_i,
  output logic [NUM_NODES-1:0][31:0] rcv_src_o,
  output logic [NUM_NODES-1:0][31:0] rcv_tag_o,
  output logic [NUM_NODES-1:0][63:0] rcv_msg_o,
  output logic                       drop_o
`ifdef BUS_ROUTER_DROP_COUNT_EN
  ,
  output logic [15:0]                drop_count_o
`endif
);

  localparam int SW = $clog2(NUM_NODES);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [SW-1:0] src;
    logic [31:0]   tag;
    logic [63:0]   msg;
  } entry_t;

  entry_t        mem_q    [NUM_NODES][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q [NUM_NODES];
  logic [AW-1:0] rd_ptr_q [NUM_NODES];
  logic [AW:0]   cnt_q    [NUM_NODES];
  logic [SW-1:0] rr_ptr_q [NUM_NODES];
  logic [SW-1:0] rr_ptr_d [NUM_NODES];
  logic [SW-1:0] gnt_idx  [NUM_NODES];
  logic [NUM_NODES-1:0] req [NUM_NODES];

  logic [NUM_NODES-1:0] bad_dst;
  logic [NUM_NODES-1:0] full;
  logic [NUM_NODES-1:0] push;
  logic [NUM_NODES-1:0] pop;

  // Full 32-bit address compare: any destination at or above NUM_NODES is discarded.
  always_comb begin : decode
    bad_dst = '0;
    for (int s = 0; s < NUM_NODES; s++) begin
      bad_dst[s] = snd_val_i[s] && (snd_dst_i[s] >= 32'(NUM_NODES));
    end
    for (int d = 0; d < NUM_NODES; d++) begin
      req[d] = '0;
      for (int s = 0; s < NUM_NODES; s++) begin
        req[d][s] = snd_val_i[s] && (snd_dst_i[s] == 32'(d));
      end
    end
  end

  always_comb begin : status
    rcv_val_o = '0;
    full      = '0;
    for (int d = 0; d < NUM_NODES; d++) begin
      rcv_val_o[d] = (cnt_q[d] != '0);
      full[d]      = (cnt_q[d] == (AW + 1)'(FIFO_DEPTH));
    end
    pop = rcv_val_o & rcv_rdy_i;
  end

  // NOTE: every variable written here gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin : arbitrate
    int            idx;
    logic [SW-1:0] cand;
    idx  = 0;
    cand = '0;
    push = '0;
    for (int d = 0; d < NUM_NODES; d++) begin
      gnt_idx[d]  = '0;
      rr_ptr_d[d] = rr_ptr_q[d];
      // A full FIFO still accepts when its head leaves this same cycle.
      if (!rst && (!full[d] || rcv_rdy_i[d])) begin
        for (int k = 0; k < NUM_NODES; k++) begin
          idx = int'(rr_ptr_q[d]) + k;
          if (idx >= NUM_NODES) idx = idx - NUM_NODES;
          cand = SW'(idx);
          if (!push[d] && req[d][cand]) begin
            push[d]    = 1'b1;
            gnt_idx[d] = cand;
          end
        end
      end
      if (push[d]) begin
        rr_ptr_d[d] = (gnt_idx[d] == SW'(NUM_NODES - 1)) ? '0 : gnt_idx[d] + SW'(1);
      end
    end
  end

  always_comb begin : ack
    snd_ack_o = rst ? '0 : bad_dst;
    for (int d = 0; d < NUM_NODES; d++) begin
      if (push[d]) snd_ack_o[gnt_idx[d]] = 1'b1;
    end
  end

  assign drop_o = !rst && (|bad_dst);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < NUM_NODES; d++) begin
        wr_ptr_q[d] <= '0;
        rd_ptr_q[d] <= '0;
        cnt_q[d]    <= '0;
        rr_ptr_q[d] <= '0;
      end
    end else begin
      for (int d = 0; d < NUM_NODES; d++) begin
        if (push[d]) wr_ptr_q[d] <= wr_ptr_q[d] + AW'(1);
        if (pop[d])  rd_ptr_q[d] <= rd_ptr_q[d] + AW'(1);
        if (push[d] && !pop[d])      cnt_q[d] <= cnt_q[d] + (AW + 1)'(1);
        else if (!push[d] && pop[d]) cnt_q[d] <= cnt_q[d] - (AW + 1)'(1);
        rr_ptr_q[d] <= rr_ptr_d[d];
      end
    end
  end

  // NOTE: storage is deliberately not reset; the counters define validity and the outputs are masked when empty.
  always_ff @(posedge clk) begin
    for (int d = 0; d < NUM_NODES; d++) begin
      if (push[d]) begin
        mem_q[d][wr_ptr_q[d]] <= '{src: gnt_idx[d],
                                   tag: snd_tag_i[gnt_idx[d]],
                                   msg: snd_msg_i[gnt_idx[d]]};
      end
    end
  end

  always_comb begin : head
    rcv_src_o = '0;
    rcv_tag_o = '0;
    rcv_msg_o = '0;
    for (int d = 0; d < NUM_NODES; d++) begin
      if (rcv_val_o[d]) begin
        rcv_src_o[d] = 32'(mem_q[d][rd_ptr_q[d]].src);
        rcv_tag_o[d] = mem_q[d][rd_ptr_q[d]].tag;
        rcv_msg_o[d] = mem_q[d][rd_ptr_q[d]].msg;
      end
    end
  end

`ifdef BUS_ROUTER_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;
  logic [16:0] drop_sum;

  // Several sources may drop in one cycle; the 17-bit sum flags overflow for saturation.
  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int s = 0; s < NUM_NODES; s++) begin
      if (bad_dst[s]) drop_sum = drop_sum + 17'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign drop_count_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bus_message_router.sv
// Randomized scoreboard bench for bus_message_router: a queue-based model predicts acks and deliveries.
module tb_bus_message_router;

  localparam int N     = 4;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]       snd_val_i, snd_ack_o, rcv_val_o, rcv_rdy_i;
  logic [N-1:0][31:0] snd_dst_i, snd_tag_i, rcv_src_o, rcv_tag_o;
  logic [N-1:0][63:0] snd_msg_i, rcv_msg_o;
  logic               drop_o;
`ifdef BUS_ROUTER_DROP_COUNT_EN
  logic [15:0]        drop_count_o;
  int                 dcnt;
`endif

  bus_message_router #(.NUM_NODES(N), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .snd_val_i (snd_val_i),
    .snd_ack_o (snd_ack_o),
    .snd_dst_i (snd_dst_i),
    .snd_tag_i (snd_tag_i),
    .snd_msg_i (snd_msg_i),
    .rcv_val_o (rcv_val_o),
    .rcv_rdy_i (rcv_rdy_i),
    .rcv_src_o (rcv_src_o),
    .rcv_tag_o (rcv_tag_o),
    .rcv_msg_o (rcv_msg_o),
    .drop_o    (drop_o)
`ifdef BUS_ROUTER_DROP_COUNT_EN
    ,
    .drop_count_o (drop_count_o)
`endif
  );

  typedef struct {
    int          src;
    logic [31:0] tag;
    logic [63:0] msg;
  } exp_t;

  exp_t       exp_q [N][$];
  int         occ [N];
  int         rr  [N];
  logic [N-1:0] acked;
  int         checks = 0;
  int         errors = 0;
  int         p_val, p_rdy, p_inval, fix_dst;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bad_addr();
    case ($urandom_range(3))
      0:       return 32'(N);
      1:       return 32'h10;
      2:       return 32'hFFFF_FFFF;
      default: return 32'h1 << $urandom_range(31, 4);
    endcase
  endfunction

  // One cycle: drive inputs after the falling edge, then predict and check the combinational response.
  task automatic step(input bit rst_v);
    logic [N-1:0] exp_ack;
    int           drops;
    int           s;
    bit           pop_m, can, done;
    @(negedge clk);
    rst = rst_v;
    for (int i = 0; i < N; i++) begin
      if (!snd_val_i[i] || acked[i]) begin
        snd_val_i[i] = ($urandom_range(99) < p_val);
        if ($urandom_range(99) < p_inval) snd_dst_i[i] = bad_addr();
        else if (fix_dst >= 0)            snd_dst_i[i] = 32'(fix_dst);
        else                              snd_dst_i[i] = 32'($urandom_range(N - 1));
        snd_tag_i[i] = $urandom;
        snd_msg_i[i] = {$urandom, $urandom};
      end
      rcv_rdy_i[i] = ($urandom_range(99) < p_rdy);
    end
    #2;
    exp_ack = '0;
    drops   = 0;
    if (rst_v) begin
      for (int d = 0; d < N; d++) begin
        occ[d] = 0;
        rr[d]  = 0;
        exp_q[d].delete();
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (snd_val_i[i] && snd_dst_i[i] >= 32'(N)) begin
          exp_ack[i] = 1'b1;
          drops++;
        end
      end
      for (int d = 0; d < N; d++) begin
        pop_m = rcv_rdy_i[d] && (occ[d] > 0);
        can   = (occ[d] < DEPTH) || pop_m;
        done  = 1'b0;
        for (int k = 0; k < N; k++) begin
          s = (rr[d] + k) % N;
          if (can && !done && snd_val_i[s] && snd_dst_i[s] == 32'(d)) begin
            done       = 1'b1;
            exp_ack[s] = 1'b1;
            exp_q[d].push_back('{s, snd_tag_i[s], snd_msg_i[s]});
            rr[d] = (s + 1) % N;
          end
        end
        occ[d] = occ[d] + int'(done) - int'(pop_m);
      end
    end
    check("snd_ack", 64'(snd_ack_o), 64'(exp_ack));
    check("drop", 64'(drop_o), 64'(drops > 0));
`ifdef BUS_ROUTER_DROP_COUNT_EN
    check("drop_count", 64'(drop_count_o), 64'(dcnt));
    if (rst_v) dcnt = 0;
    else       dcnt = (dcnt + drops > 65535) ? 65535 : dcnt + drops;
`endif
    acked = exp_ack;
  endtask

  task automatic check_idle();
    for (int d = 0; d < N; d++) begin
      check($sformatf("idle_val[%0d]", d), 64'(rcv_val_o[d]), 64'd0);
      check($sformatf("idle_src[%0d]", d), 64'(rcv_src_o[d]), 64'd0);
      check($sformatf("idle_tag[%0d]", d), 64'(rcv_tag_o[d]), 64'd0);
      check($sformatf("idle_msg[%0d]", d), rcv_msg_o[d], 64'd0);
    end
  endtask

  task automatic run(input int cycles, input int v, input int r, input int inv, input int fd);
    p_val = v; p_rdy = r; p_inval = inv; fix_dst = fd;
    repeat (cycles) step(1'b0);
  endtask

  // Monitor: whenever a head is consumed, compare it with the oldest expected entry for that destination.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      for (int d = 0; d < N; d++) begin
        check($sformatf("rcv_val[%0d]", d), 64'(rcv_val_o[d]), 64'(exp_q[d].size() != 0));
        if (rcv_val_o[d] && rcv_rdy_i[d] && exp_q[d].size() != 0) begin
          e = exp_q[d].pop_front();
          check($sformatf("rcv_src[%0d]", d), 64'(rcv_src_o[d]), 64'(e.src));
          check($sformatf("rcv_tag[%0d]", d), 64'(rcv_tag_o[d]), 64'(e.tag));
          check($sformatf("rcv_msg[%0d]", d), rcv_msg_o[d], e.msg);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 5000000", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    snd_val_i = '0; snd_dst_i = '0; snd_tag_i = '0; snd_msg_i = '0;
    rcv_rdy_i = '0; acked = '0;
`ifdef BUS_ROUTER_DROP_COUNT_EN
    dcnt = 0;
`endif
    for (int d = 0; d < N; d++) begin
      occ[d] = 0;
      rr[d]  = 0;
    end
    // Senders active with bad destinations during reset: no ack, no drop.
    p_val = 100; p_rdy = 50; p_inval = 50; fix_dst = -1;
    step(1'b1);
    step(1'b1);
    p_val = 0;
    step(1'b0);
    check_idle();

    run(300, 70, 60, 10, -1);   // mixed traffic
    run(60, 100, 100, 0, 2);    // everyone contends for node 2
    run(12, 100, 0, 0, 0);      // backpressure on node 0
    run(12, 100, 100, 0, 0);    // release: full pass-through
    run(12, 100, 0, 5, -1);     // fill all FIFOs
    step(1'b1);                 // reset with messages queued
    p_val = 0;
    step(1'b0);
    check_idle();
    run(20, 100, 100, 0, 2);    // first grant must go to node 0
    run(300, 60, 50, 20, -1);
`ifdef BUS_ROUTER_DROP_COUNT_EN
    run(16500, 100, 50, 100, -1);  // more than 0x10000 drops: saturate
`endif
    run(4, 0, 100, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
